// File: rtl/sp1_ram_arb_pkg.sv
// sp1_ram_arb_pkg
// Shared types for the sp1 RAM arbiter: the arbiter FSM state encoding and
// the requester identifiers used for priority and read-return steering.
package sp1_ram_arb_pkg;

    typedef enum logic [1:0] {
        SP1_ARB_ARB   = 2'd0,
        SP1_ARB_HOLD0 = 2'd1,
        SP1_ARB_HOLD1 = 2'd2
    } sp1_arb_state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/sp1_ram_arb.sv
// sp1_ram_arb
// Two-requester round-robin arbiter in front of a single-port sp1_ram with a
// one-cycle registered read. Requester 0 is the evaluator heap path,
// requester 1 the loader/dump path. A requester may assert lock to keep the
// RAM for a burst.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rN_req/we/lock        request, write select, keep ownership after grant
//   rN_adrs/din           access address and write data
//   rN_gnt                combinational grant (write completes on grant)
//   rN_rvalid/rdata       read return, one cycle after a read grant
//   ram_cs/we/adrs/din    drive to sp1_ram, zero when idle
//   ram_dout              registered read data from sp1_ram
module sp1_ram_arb
    import sp1_ram_arb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_adrs,
    input  logic [DW-1:0] r0_din,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_adrs,
    input  logic [DW-1:0] r1_din,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_adrs,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    sp1_arb_state_t state, state_nx;
    logic           prio, prio_nx;     // requester preferred on a tie in ARB
    logic           pend_v, pend_id;   // read issued last cycle, and its owner
    logic           gnt0, gnt1;
    logic           rd_fire;
    logic           proto_err;

    // Unknown req/lock is a protocol error: suppress grants for that cycle.
    // Evaluates to 0 in synthesis and 2-state simulation.
    always_comb begin
        proto_err = $isunknown({r0_req, r0_lock, r1_req, r1_lock});
    end

    always_comb begin
        state_nx = state;
        prio_nx  = prio;
        gnt0     = 1'b0;
        gnt1     = 1'b0;

        if (!rst && !proto_err) begin
            case (state)
                SP1_ARB_ARB: begin
                    if (r0_req && (!r1_req || prio == REQ_ID0))
                        gnt0 = 1'b1;
                    else if (r1_req)
                        gnt1 = 1'b1;
                end
                SP1_ARB_HOLD0: gnt0 = r0_req;
                SP1_ARB_HOLD1: gnt1 = r1_req;
                default: ;
            endcase

            // Every grant, held or not, hands priority to the other side so
            // the loser of a burst wins the first tie after release.
            if (gnt0)
                prio_nx = REQ_ID1;
            else if (gnt1)
                prio_nx = REQ_ID0;

            case (state)
                SP1_ARB_ARB: begin
                    if (gnt0 && r0_lock)
                        state_nx = SP1_ARB_HOLD0;
                    else if (gnt1 && r1_lock)
                        state_nx = SP1_ARB_HOLD1;
                end
                // Lock is sampled each cycle of a hold, whether or not the
                // owner is requesting.
                SP1_ARB_HOLD0: if (!r0_lock) state_nx = SP1_ARB_ARB;
                SP1_ARB_HOLD1: if (!r1_lock) state_nx = SP1_ARB_ARB;
                default:       state_nx = SP1_ARB_ARB;
            endcase
        end
    end

    always_comb begin
        rd_fire = (gnt0 && !r0_we) || (gnt1 && !r1_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SP1_ARB_ARB;
            prio    <= REQ_ID0;
            pend_v  <= 1'b0;
            pend_id <= REQ_ID0;
        end else begin
            state  <= state_nx;
            prio   <= prio_nx;
            pend_v <= rd_fire;
            if (rd_fire)
                pend_id <= gnt1 ? REQ_ID1 : REQ_ID0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!proto_err)
                else $warning("sp1_ram_arb: unknown value on req/lock, grants suppressed");
    end

    always_comb begin
        r0_gnt = gnt0;
        r1_gnt = gnt1;
        ram_cs = gnt0 || gnt1;
        if (gnt0) begin
            ram_we   = r0_we;
            ram_adrs = r0_adrs;
            ram_din  = r0_din;
        end else if (gnt1) begin
            ram_we   = r1_we;
            ram_adrs = r1_adrs;
            ram_din  = r1_din;
        end else begin
            ram_we   = 1'b0;
            ram_adrs = '0;
            ram_din  = '0;
        end
    end

    // rvalid is also gated by rst so a read granted just before reset never
    // reports during the reset cycle.
    always_comb begin
        r0_rvalid = pend_v && (pend_id == REQ_ID0) && !rst;
        r1_rvalid = pend_v && (pend_id == REQ_ID1) && !rst;
        r0_rdata  = ram_dout;
        r1_rdata  = ram_dout;
    end

endmodule

// File: doc/sp1_ram_arb.md
Name: sp1_ram_arb

Overview:
Two-requester arbiter and sequencer in front of one sp1_ram instance (single port, 1-cycle registered read).
- Port 0 is the evaluator heap path; port 1 is the loader/dump path.
- Grants one access per cycle, round-robin, with an optional lock so one requester can own the RAM for a burst.
- Drives sp1_ram cs/we/adrs/din and steers the returned dout back to the requester with a valid strobe.

Parameters:
AW, 10, RAM address width (must match sp1_ram AW)
DW, 32, RAM data width (must match sp1_ram DW)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous, active-high reset
r0_req  input  1  requester 0 access request, held until granted
r0_we  input  1  1 = write, 0 = read
r0_lock  input  1  keep ownership after this grant
r0_adrs  input  AW  address
r0_din  input  DW  write data
r0_gnt  output  1  access accepted this cycle (combinational)
r0_rvalid  output  1  read data valid (registered, one cycle after read grant)
r0_rdata  output  DW  read data
r1_req, r1_we, r1_lock, r1_adrs, r1_din, r1_gnt, r1_rvalid, r1_rdata  (same as r0_*, requester 1)
ram_cs  output  1  to sp1_ram cs
ram_we  output  1  to sp1_ram we
ram_adrs  output  AW  to sp1_ram adrs
ram_din  output  DW  to sp1_ram din
ram_dout  input  DW  from sp1_ram dout

Behaviour:
- Reset (rst=1 at posedge):
  - state=ARB, prio=0 (requester 0 preferred), pend_v=0.
  - While rst=1: r0_gnt=r1_gnt=0, ram_cs=0, r0_rvalid=r1_rvalid=0.
- FSM states: ARB, HOLD0, HOLD1.
- ARB:
  - Only one requester asserts req: it is granted.
  - Both assert req: requester==prio is granted.
  - Neither: no grant, ram_cs=0.
  - At posedge after a grant to n: prio <= other requester; if rn_lock=1 then state <= HOLDn.
- HOLDn:
  - rn_gnt = rn_req; the other requester's gnt is forced to 0 even if it requests.
  - Next state = ARB when rn_lock=0 is sampled at a posedge (with or without a request); otherwise stay.
  - prio <= other requester on each HOLD grant (fairness is restored on exit).
- RAM drive (combinational mux of the granted requester):
  - ram_cs = r0_gnt | r1_gnt.
  - ram_we, ram_adrs, ram_din = granted requester's we/adrs/din.
  - With no grant: ram_we=0, ram_adrs=0, ram_din=0. No X is propagated to the RAM.
- Read return:
  - At the posedge of a read grant (gnt & ~we): pend_v <= 1, pend_id <= n; otherwise pend_v <= 0.
  - rn_rvalid = pend_v & (pend_id==n).
  - r0_rdata = r1_rdata = ram_dout. Data is meaningful only when rvalid is high.
  - Latency: grant in cycle t, rvalid and data in cycle t+1.
  - Back-to-back reads, including alternating requesters, give one rvalid per cycle.
- Writes produce no response; gnt is the completion.
- Read-after-write to the same address in consecutive granted cycles returns the new data, because the RAM commits the write at posedge.
- Requester rule: must hold req/we/adrs/din/lock stable until gnt. Dropping req without a grant is legal and has no side effects.
- Reset mid-operation: a pending read is discarded (no rvalid after reset) and any HOLD is released.
- X on req or lock is treated as a protocol error. Simulation only: $display a warning, and grants go to 0 for that cycle.

Decomposition:
- SP1_ARB_ARB/HOLD0/HOLD1 state encodings (2-bit) go in sp1_common.h next to the existing sp1 defines.
- No sub-module. A single module holds the FSM, prio flop, pend register and output muxes.

Test Plan:
- Single requester: r0 writes 0x12345678 to 0x005, then reads 0x005. Expect r0_gnt in the request cycle, ram_cs=1/ram_we=1 on the write, and r0_rvalid=1 with r0_rdata=0x12345678 exactly one cycle after the read grant; r1_rvalid stays 0.
- Contention: after reset both request continuously with reads of 0x001 (r0) and 0x002 (r1). Expect grant order r0, r1, r0, r1, and each rvalid/rdata returned to the correct owner the next cycle.
- Lock: r1 asserts lock for 3 writes (0x3FC..0x3FE = 0xcafecafe) while r0 requests throughout. Expect r0_gnt=0 for those 3 cycles, release when r1_lock=0, then r0 granted next because prio=0.
- Idle bus: no requests. Expect ram_cs=0, ram_we=0, ram_adrs=0, ram_din=0 (no X), and both rvalid=0.
- Reset mid-read: grant an r0 read of 0x3FF, assert rst at the next posedge. Expect r0_rvalid never asserts, state=ARB and prio=0 afterwards, and an immediate r1 request after reset granted first.
- Write/read same address back-to-back: r0 writes 0xbeefbeef to 0x3FF; r1 reads 0x3FF the next cycle. Expect r1_rdata=0xbeefbeef with r1_rvalid.
